// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running VGA raster timing generator. The 100 MHz system clock is
// divided by four to make the pixel strobe. The raster position, the sync
// pulses, blanking and the frame markers all advance on that strobe.
//
// The sync and blank outputs are registered. They are decoded from the
// *next* counter values on the same edge that loads the counters. As a
// result they always agree with the hcount/vcount presented alongside them,
// and downstream overlays see no skew between position and timing.

module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixpulse,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame
);

    localparam logic [9:0] H_TOTAL  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] H_LAST   = H_TOTAL - 10'd1;
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0] V_TOTAL  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] V_LAST   = V_TOTAL - 10'd1;
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [1:0] div;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;
    logic       hsync_next;
    logic       vsync_next;
    logic       blank_next;

    // Free-running divide-by-four prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    // Pixel strobe, registered so that it is high exactly while div == 3.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixpulse <= 1'b0;
        end else begin
            pixpulse <= (div == 2'd2);
        end
    end

    // Next raster position and the decodes of that position. The >=
    // compares also pull any out-of-range value straight back to zero.
    always_comb begin
        h_wrap     = (hcount >= H_LAST);
        v_wrap     = (vcount >= V_LAST);
        frame_wrap = h_wrap && v_wrap;
        h_next     = h_wrap ? 10'd0 : hcount + 10'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vcount + 10'd1;
        end
        hsync_next = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_next = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
        blank_next = (h_next >= H_VIS) || (v_next >= V_VIS);
    end

    // Raster counters advance on the edge that ends a pixpulse-high cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount <= 10'd0;
            vcount <= 10'd0;
        end else if (pixpulse) begin
            hcount <= h_next;
            vcount <= v_next;
        end
    end

    // Sync and blank are loaded together with the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            blank <= 1'b0;
        end else if (pixpulse) begin
            hsync <= hsync_next;
            vsync <= vsync_next;
            blank <= blank_next;
        end
    end

    // Frame marker: a one-clk pulse in the first cycle that shows (0,0),
    // plus a wrapping frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_start <= 1'b0;
            frame       <= 8'd0;
        end else begin
            frame_start <= pixpulse && frame_wrap;
            if (pixpulse && frame_wrap) begin
                frame <= frame + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three instances share one clock and one reset:
//   dut_a - the default 640x480 timing;
//   dut_b - a tiny raster (7x6), small enough to run whole frames and
//           the frame-counter wrap;
//   dut_c - the same tiny raster built with SYNC_POL = 1.
// The expected values come from a closed-form model of the elapsed clock
// count since reset release, plus a hand-written table for the first cycles.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic       pix_a, hs_a, vs_a, bl_a, fs_a;
    logic [9:0] h_a, v_a;
    logic [7:0] fr_a;
    logic       pix_b, hs_b, vs_b, bl_b, fs_b;
    logic [9:0] h_b, v_b;
    logic [7:0] fr_b;
    logic       pix_c, hs_c, vs_c, bl_c, fs_c;
    logic [9:0] h_c, v_c;
    logic [7:0] fr_c;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst), .pixpulse(pix_a), .hcount(h_a), .vcount(v_a),
        .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .frame_start(fs_a), .frame(fr_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(3), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .rst(rst), .pixpulse(pix_b), .hcount(h_b), .vcount(v_b),
        .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .frame_start(fs_b), .frame(fr_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(3), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst), .pixpulse(pix_c), .hcount(h_c), .vcount(v_c),
        .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .frame_start(fs_c), .frame(fr_c)
    );

    typedef struct {
        int         cyc;
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
    } vec_t;

    vec_t tbl [13];
    int   checks = 0;
    int   errors = 0;

    // Packed output word: {pix, h, v, hs, vs, blank, fs, frame}.
    function automatic logic [32:0] model(input int n, input int ha, input int hf,
                                          input int hsw, input int hb, input int va,
                                          input int vf, input int vsw, input int vb,
                                          input logic pol);
        int   ht, vt, p, h, v, fr;
        logic pix, hs, vs, bl, fs;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        p   = n / 4;
        h   = p % ht;
        v   = (p / ht) % vt;
        fr  = (p / (ht * vt)) % 256;
        pix = ((n % 4) == 3);
        hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
        vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
        bl  = (h >= ha) || (v >= va);
        fs  = ((n % 4) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
        return {pix, 10'(h), 10'(v), hs, vs, bl, fs, 8'(fr)};
    endfunction

    task automatic check(input string name, input int n, input logic [32:0] act,
                         input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %h want %h", name, n, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a"}, 0, {pix_a, h_a, v_a, hs_a, vs_a, bl_a, fs_a, fr_a},
              {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        check({tag, "_b"}, 0, {pix_b, h_b, v_b, hs_b, vs_b, bl_b, fs_b, fr_b},
              {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        check({tag, "_c"}, 0, {pix_c, h_c, v_c, hs_c, vs_c, bl_c, fs_c, fr_c},
              {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    endtask

    // Releases reset on a falling edge and checks every cycle after it.
    task automatic run_from_release(input int ncyc, input bit long_run);
        int hs_low_cnt = 0;
        int blank_cnt  = 0;
        int fs_cnt     = 0;
        bit seen255    = 0;
        bit wrapped    = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            #1;
            if (n < 13) begin
                check("table_a", n, {pix_a, h_a, v_a, hs_a, vs_a, bl_a, fs_a, fr_a},
                      {tbl[n].pix, tbl[n].h, tbl[n].v, tbl[n].hs, tbl[n].vs,
                       tbl[n].bl, tbl[n].fs, 8'd0});
            end
            check("model_a", n, {pix_a, h_a, v_a, hs_a, vs_a, bl_a, fs_a, fr_a},
                  model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            check("model_b", n, {pix_b, h_b, v_b, hs_b, vs_b, bl_b, fs_b, fr_b},
                  model(n, 3, 1, 2, 1, 2, 1, 2, 1, 1'b0));
            check("model_c", n, {pix_c, h_c, v_c, hs_c, vs_c, bl_c, fs_c, fr_c},
                  model(n, 3, 1, 2, 1, 2, 1, 2, 1, 1'b1));
            if (n < 3200 && pix_a && !hs_a) hs_low_cnt++;
            if (n < 3200 && pix_a && bl_a) blank_cnt++;
            if (fs_b) fs_cnt++;
            if (fr_b == 8'd255) seen255 = 1;
            if (seen255 && fr_b == 8'd0) wrapped = 1;
            @(negedge clk);
        end
        if (long_run) begin
            check("hsync_low_periods", 0, 33'(hs_low_cnt), 33'd96);
            check("blank_periods_line0", 0, 33'(blank_cnt), 33'd160);
            check("frame_start_pulses_b", 0, 33'(fs_cnt), 33'd257);
            check("frame_wrap_255_0_b", 0, 33'(wrapped), 33'd1);
        end
    endtask

    initial begin
        // Hand-derived start-up sequence for the default instance.
        tbl[0]  = '{0,  1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2,  1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{3,  1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4,  1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{5,  1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{6,  1'b0, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{7,  1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{8,  1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{9,  1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{10, 1'b0, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{11, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{12, 1'b0, 10'd3, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Hold reset across a few edges.
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("in_reset");

        // 257 tiny frames (also covers 13+ default lines).
        run_from_release(257 * 168 + 8, 1'b1);

        // Wait until dut_b shows hsync and vsync both asserted, then reset mid-pixel.
        begin
            int  budget = 0;
            bit  found  = 0;
            while (budget < 400 && !found) begin
                #1;
                if (h_b == 10'd4 && v_b == 10'd3 && pix_b == 1'b0) begin
                    found = 1;
                end else begin
                    @(negedge clk);
                    budget++;
                end
            end
            check("midframe_point_found", budget, 33'(found), 33'd1);
            check("midframe_syncs_b", 0, {31'd0, hs_b, vs_b}, {31'd0, 1'b0, 1'b0});
            #1;
            rst = 1'b0;
            #1;
            check_reset_state("async_reset");
        end

        // Restart after the mid-frame reset must match the first release.
        run_from_release(300, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running 640x480@60 Hz VGA raster timing generator, clocked from the 100 MHz system clock.
- Produces the 25 MHz pixel strobe (pixpulse), raster position (hcount/vcount), sync pulses, blanking, and per-frame markers.
- Sits directly upstream of every on-screen overlay block (score/text overlays, sprites) and the final pixel-colour mux; all of them consume hcount, vcount and pixpulse from here.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  reset, asynchronous, active-low
- pixpulse  output  1  one-clk strobe every 4 clocks (25 MHz pixel rate)
- hcount  output  10  current pixel column, 0..H_TOTAL-1
- vcount  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync at SYNC_POL while asserted
- vsync  output  1  vertical sync at SYNC_POL while asserted
- blank  output  1  1 outside the visible area
- frame_start  output  1  one-clk pulse on the first clock of each new frame
- frame  output  8  frame counter, wraps 255->0

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values (while rst = 0):
  - Prescaler div = 0; pixpulse = 0; hcount = 0; vcount = 0.
  - hsync = vsync = ~SYNC_POL (deasserted).
  - blank = 0; frame_start = 0; frame = 0.
- Prescaler:
  - 2-bit div increments every clk.
  - pixpulse is registered and is high exactly in the clk cycle where div == 3.
  - After reset release, the first pixpulse falls in the 4th clk cycle (cycle index 3). The period is then exactly 4 clk, with duty 1/4.
- Counters (advance only on the rising edge that ends a pixpulse-high cycle):
  - hcount: H_TOTAL-1 -> 0, else +1.
  - vcount: +1 when hcount wraps. vcount V_TOTAL-1 -> 0 on the same edge that hcount wraps from H_TOTAL-1.
  - Counters never hold out-of-range values. Between pixpulses, all position-derived outputs are stable.
- Registered decodes, updated on the same edge as the counters from the next counter values, so they are always consistent with the presented hcount/vcount (zero-latency relative to position):
  - hsync asserted iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank = (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE).
- Frame markers:
  - On the edge where (hcount, vcount) wraps to (0, 0), frame increments (mod 256) and frame_start is set high for exactly one clk cycle. That cycle is the first cycle in which (0, 0) is presented.
  - frame_start is not asserted on reset release.
- Reset mid-frame: all state returns immediately to the reset values. Raster restarts at (0, 0) and the frame count restarts at 0. No partial sync pulse is held over.
- No inputs other than clk/rst. The block is free-running and has no stall.

Test Plan:
- Reset release -> pixpulse first high at clk cycle 3, then cycles 7, 11, ...; hcount = 0 until the edge ending cycle 3, then 1; hsync = vsync = 1, blank = 0 during reset.
- Run 800 pixpulses -> hcount sequence 0..799 then 0; vcount goes 0 -> 1 on that wrap; hsync low for exactly 96 pixpulse periods starting at hcount = 656; blank = 1 exactly for hcount 640..799.
- Run a full frame (800*525*4 = 1,680,000 clk) -> frame_start high for one clk at the (0,0) wrap; frame 0 -> 1; vsync low exactly for vcount 490 and 491 (1600 pixpulses); blank = 1 for all vcount >= 480.
- Run 256 frames -> frame wraps 255 -> 0 with frame_start still pulsing once per frame; no extra pulses.
- Assert rst at hcount = 700, vcount = 490 (hsync and vsync both asserted) -> outputs go to reset values asynchronously, before the next clk edge; after release, timing matches the first test.
- SYNC_POL = 1 build -> hsync high only for hcount 656..751, vsync high only for vcount 490..491; reset level 0.
